// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic analyser. It arms, stores samples into a ring buffer,
// counts the post-trigger delay, then replays the captured window over a valid/ready port.
module capture_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_stb_i,
  input  logic [CNT_W-1:0]  read_cnt_i,
  input  logic [CNT_W-1:0]  delay_cnt_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              smpl_stb_i,
  input  logic              trg_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic              rd_vld_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_rdy_i,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    READOUT   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  read_q;
  logic [CNT_W-1:0]  delay_q;
  logic [CNT_W-1:0]  dcnt;
  logic [ADDR_W:0]   rcnt;
  logic [ADDR_W:0]   eff_read;
  logic [ADDR_W-1:0] stop_addr;
  logic              last_wr;

  // Read-port handshake: rd_addr_o is offered while rd_vld_o is high and is held
  // unchanged until a cycle with rd_vld_o & rd_rdy_i, which counts as one transfer.
  always_comb begin
    eff_read  = (read_q > CNT_W'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : read_q[ADDR_W:0];
    stop_addr = mem_waddr_o + ADDR_W'(1);
    mem_we_o  = smpl_stb_i && (state == ARMED || state == TRIGGERED);
    last_wr   = smpl_stb_i &&
                ((state == ARMED && trg_i && delay_q == '0) ||
                 (state == TRIGGERED && dcnt == CNT_W'(1)));
  end

  assign armed_o     = (state == ARMED);
  assign triggered_o = (state == TRIGGERED);
  assign dbg_state   = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      read_q      <= '0;
      delay_q     <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      mem_waddr_o <= '0;
      rd_addr_o   <= '0;
      rd_vld_o    <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state    <= IDLE;
        rd_vld_o <= 1'b0;
        rcnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_stb_i) begin
              read_q  <= read_cnt_i;
              delay_q <= delay_cnt_i;
            end
            if (arm_i) begin
              state       <= ARMED;
              mem_waddr_o <= '0;
            end
          end
          ARMED: begin
            if (smpl_stb_i) begin
              mem_waddr_o <= stop_addr;
              if (trg_i && delay_q != '0) begin
                state <= TRIGGERED;
                dcnt  <= delay_q;
              end
            end
          end
          TRIGGERED: begin
            if (smpl_stb_i) begin
              mem_waddr_o <= stop_addr;
              dcnt        <= dcnt - CNT_W'(1);
            end
          end
          READOUT: begin
            // A zero-length window falls through here to finish one cycle after entry.
            if (rcnt == '0) begin
              done_o <= 1'b1;
              state  <= IDLE;
            end else if (rd_vld_o && rd_rdy_i) begin
              rd_addr_o <= rd_addr_o + ADDR_W'(1);
              rcnt      <= rcnt - (ADDR_W+1)'(1);
              if (rcnt == (ADDR_W+1)'(1)) begin
                rd_vld_o <= 1'b0;
                done_o   <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
        // The window ends at the address just past the final stored sample.
        if (last_wr) begin
          state     <= READOUT;
          rd_addr_o <= stop_addr - eff_read[ADDR_W-1:0];
          rcnt      <= eff_read;
          rd_vld_o  <= (eff_read != '0);
        end
      end
    end
  end

endmodule
